// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame parser.
package uart_pkg;

  // Parser states.
  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  // Error codes reported on err_code.
  typedef enum logic [1:0] {
    ERR_TIMEOUT = 2'd0,
    ERR_BAD_LEN = 2'd1,
    ERR_BAD_CHK = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: one synchronous write port, one combinational read port.
// The contents are not reset; readers only look at entries written for
// the current frame.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // Store one payload byte per write strobe.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_parser.sv
// Extracts SYNC/LEN/payload/CHK frames from a strobed UART byte stream,
// validates them, and replays the payload on a ready/valid byte stream.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int IDX_W  = $clog2(MAX_LEN + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC);
  localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       LEN_MAX8 = 8'(MAX_LEN);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   len_reg, len_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [IDX_W-1:0]   rd_idx_reg, rd_idx_next;
  logic [7:0]         sum_reg, sum_next;
  logic [TMO_W-1:0]   tmo_reg, tmo_next;
  logic               frame_ok_reg, frame_ok_next;
  logic               frame_err_reg, frame_err_next;
  logic [1:0]         err_code_reg, err_code_next;
  logic               wr_en;
  logic               in_frame;
  logic               last_rd;
  logic [7:0]         rd_data;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (BUF_AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (idx_reg[BUF_AW-1:0]),
    .wr_data (in_data),
    .rd_addr (rd_idx_reg[BUF_AW-1:0]),
    .rd_data (rd_data)
  );

  assign in_frame = (state_reg == LEN) || (state_reg == PAYLOAD) || (state_reg == CHK);
  assign last_rd  = (rd_idx_reg == len_reg - 1'b1);

  // State and datapath registers; reset aborts any frame without pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= HUNT;
      len_reg       <= '0;
      idx_reg       <= '0;
      rd_idx_reg    <= '0;
      sum_reg       <= '0;
      tmo_reg       <= '0;
      frame_ok_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      err_code_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      idx_reg       <= idx_next;
      rd_idx_reg    <= rd_idx_next;
      sum_reg       <= sum_next;
      tmo_reg       <= tmo_next;
      frame_ok_reg  <= frame_ok_next;
      frame_err_reg <= frame_err_next;
      err_code_reg  <= err_code_next;
    end
  end

  // Next-state, checksum, buffer write and error/timeout decisions.
  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    idx_next       = idx_reg;
    rd_idx_next    = rd_idx_reg;
    sum_next       = sum_reg;
    tmo_next       = '0;
    frame_ok_next  = 1'b0;
    frame_err_next = 1'b0;
    err_code_next  = err_code_reg;
    wr_en          = 1'b0;

    case (state_reg)
      HUNT: begin
        if (in_valid && (in_data == SYNC_BYTE)) begin
          state_next = LEN;
        end
      end
      LEN: begin
        if (in_valid) begin
          if ((in_data == 8'h00) || (in_data > LEN_MAX8)) begin
            frame_err_next = 1'b1;
            err_code_next  = ERR_BAD_LEN;
            state_next     = HUNT;
          end else begin
            len_next   = in_data[IDX_W-1:0];
            sum_next   = in_data;
            idx_next   = '0;
            state_next = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (in_valid) begin
          wr_en    = 1'b1;
          sum_next = 8'(sum_reg + in_data);
          idx_next = idx_reg + 1'b1;
          if (idx_reg == len_reg - 1'b1) begin
            state_next = CHK;
          end
        end
      end
      CHK: begin
        if (in_valid) begin
          if (8'(sum_reg + in_data) == 8'h00) begin
            rd_idx_next = '0;
            state_next  = DRAIN;
          end else begin
            frame_err_next = 1'b1;
            err_code_next  = ERR_BAD_CHK;
            state_next     = HUNT;
          end
        end
      end
      DRAIN: begin
        // Bytes arriving while draining cannot be stored; flag and drop.
        if (in_valid) begin
          frame_err_next = 1'b1;
          err_code_next  = ERR_OVERRUN;
        end
        if (out_ready) begin
          if (last_rd) begin
            frame_ok_next = 1'b1;
            state_next    = HUNT;
          end else begin
            rd_idx_next = rd_idx_reg + 1'b1;
          end
        end
      end
      default: state_next = HUNT;
    endcase

    // Inter-byte watchdog; a byte in the expiry cycle takes precedence.
    if (in_frame && !in_valid) begin
      if (tmo_reg == TMO_LAST) begin
        frame_err_next = 1'b1;
        err_code_next  = ERR_TIMEOUT;
        state_next     = HUNT;
      end else begin
        tmo_next = tmo_reg + 1'b1;
      end
    end
  end

  assign out_valid = (state_reg == DRAIN);
  assign out_data  = out_valid ? rd_data : 8'h00;
  assign out_last  = out_valid && last_rd;
  assign frame_ok  = frame_ok_reg;
  assign frame_err = frame_err_reg;
  assign err_code  = err_code_reg;
  assign busy      = (state_reg != HUNT);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed cases plus
// randomized frames checked against a frame-level reference model.
module tb_uart_frame_parser;

  localparam int TMO = 50;
  localparam int MAXL = 16;

  typedef logic [7:0] bq_t [$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  int total = 0;
  int bad = 0;

  // Monitor records
  int         cyc = 0;
  int         tx_cyc = 0;
  logic [7:0] got_data [$];
  logic       got_last [$];
  int         err_q [$];
  int         err_cyc = 0;
  int         first_ov_cyc = -1;
  int         ok_cnt = 0;
  int         ov_cnt = 0;
  int         stall_bad = 0;
  logic       prev_stall = 1'b0;
  logic       prev_ov = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  uart_frame_parser #(
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (MAXL),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Observe outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
    end
    if (out_valid && prev_stall && ((out_data !== prev_data) || (out_last !== prev_last)))
      stall_bad++;
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    if (out_valid && !prev_ov) first_ov_cyc = cyc;
    prev_ov = out_valid;
    if (out_valid) ov_cnt++;
    if (frame_ok) ok_cnt++;
    if (frame_err) begin
      err_q.push_back(int'(err_code));
      err_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic mon_clear();
    got_data.delete();
    got_last.delete();
    err_q.delete();
    ok_cnt = 0;
    ov_cnt = 0;
    stall_bad = 0;
    first_ov_cyc = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    in_data  = b;
    in_valid = 1'b1;
    tx_cyc   = cyc;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_frame(input bq_t f);
    foreach (f[i]) send_byte(f[i]);
  endtask

  // Build a well-formed frame with random payload of the given length.
  task automatic build_good(input int len, output bq_t frame, output bq_t pay);
    int s;
    pay.delete();
    frame.delete();
    s = len;
    frame.push_back(8'hA5);
    frame.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      pay.push_back(8'($urandom_range(0, 255)));
      s += int'(pay[i]);
      frame.push_back(pay[i]);
    end
    frame.push_back(8'((256 - (s % 256)) % 256));
  endtask

  // Reference outcome: 4 = accepted, otherwise the expected error code.
  function automatic int frame_outcome(input bq_t f);
    int len;
    int s;
    len = int'(f[1]);
    if (len == 0 || len > MAXL) return 1;
    s = 0;
    for (int i = 1; i < f.size(); i++) s += int'(f[i]);
    return ((s % 256) == 0) ? 4 : 2;
  endfunction

  // Drive out_ready until frame_ok seen. mode 0: always 1, 1: toggle, 2: random.
  task automatic run_drain(input int mode, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (ok_cnt > 0) begin
        done = 1'b1;
        break;
      end
      tick();
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
    chk({tag, "_drain_done"}, int'(done), 1);
    tick();
    tick();
    out_ready = 1'b0;
  endtask

  task automatic wait_err(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (err_q.size() > 0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_err_seen"}, int'(seen), 1);
    tick();
    tick();
  endtask

  task automatic check_payload(input bq_t pay, input string tag);
    int n;
    chk({tag, "_count"}, got_data.size(), pay.size());
    n = (got_data.size() < pay.size()) ? got_data.size() : pay.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), int'(got_data[i]), int'(pay[i]));
      chk($sformatf("%s_last%0d", tag, i), int'(got_last[i]), (i == pay.size() - 1) ? 1 : 0);
    end
    chk({tag, "_ok_pulses"}, ok_cnt, 1);
    chk({tag, "_stall_stable"}, stall_bad, 0);
  endtask

  initial begin
    bq_t frame;
    bq_t pay;
    bq_t bl;
    int  chk_cyc;
    int  outcome;
    int  mode;

    // Reset state
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_frame_ok", int'(frame_ok), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_err_code", int'(err_code), 0);
    chk("rst_busy", int'(busy), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: basic frame with out_ready held high
    mon_clear();
    out_ready = 1'b1;
    pay = '{8'h11, 8'h22, 8'h33};
    frame = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_frame(frame);
    chk_cyc = tx_cyc;
    run_drain(0, "t1");
    check_payload(pay, "t1");
    chk("t1_latency", first_ov_cyc, chk_cyc + 1);
    chk("t1_no_err", err_q.size(), 0);
    $display("t1 basic frame: bytes=%0d ok=%0d", got_data.size(), ok_cnt);

    // 2: same frame with toggling out_ready
    mon_clear();
    out_ready = 1'b0;
    send_frame(frame);
    run_drain(1, "t2");
    check_payload(pay, "t2");
    chk("t2_no_err", err_q.size(), 0);
    $display("t2 toggled ready: bytes=%0d ok=%0d", got_data.size(), ok_cnt);

    // 3: bad lengths then a good frame
    mon_clear();
    bl = '{8'hA5, 8'h00};
    send_frame(bl);
    chk_cyc = tx_cyc;
    wait_err("t3a");
    chk("t3a_code", (err_q.size() > 0) ? err_q[0] : -1, 1);
    chk("t3a_timing", err_cyc, chk_cyc + 1);
    chk("t3a_pulses", err_q.size(), 1);
    $display("t3a len=0: err_code=%0d", err_code);
    mon_clear();
    bl = '{8'hA5, 8'h11};
    send_frame(bl);
    wait_err("t3b");
    chk("t3b_code", (err_q.size() > 0) ? err_q[0] : -1, 1);
    chk("t3b_busy", int'(busy), 0);
    $display("t3b len=17: err_code=%0d", err_code);
    mon_clear();
    out_ready = 1'b1;
    build_good(MAXL, frame, pay);
    send_frame(frame);
    run_drain(0, "t3c");
    check_payload(pay, "t3c");
    $display("t3c good max-length frame: bytes=%0d", got_data.size());

    // 4: bad checksum, then correct checksum
    mon_clear();
    bl = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    send_frame(bl);
    chk_cyc = tx_cyc;
    wait_err("t4a");
    chk("t4a_code", (err_q.size() > 0) ? err_q[0] : -1, 2);
    chk("t4a_timing", err_cyc, chk_cyc + 1);
    chk("t4a_no_valid", ov_cnt, 0);
    $display("t4a bad checksum: err_code=%0d", err_code);
    mon_clear();
    bl = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hCE};
    pay = '{8'h10, 8'h20};
    send_frame(bl);
    run_drain(0, "t4b");
    check_payload(pay, "t4b");
    $display("t4b good checksum: bytes=%0d", got_data.size());

    // 5: timeout mid-payload
    mon_clear();
    bl = '{8'hA5, 8'h02, 8'h10};
    send_frame(bl);
    chk_cyc = tx_cyc;
    wait_err("t5");
    chk("t5_code", (err_q.size() > 0) ? err_q[0] : -1, 0);
    chk("t5_delay", err_cyc - chk_cyc, TMO + 1);
    chk("t5_busy", int'(busy), 0);
    chk("t5_pulses", err_q.size(), 1);
    $display("t5 timeout: delay=%0d err_code=%0d", err_cyc - chk_cyc, err_code);
    mon_clear();
    build_good(5, frame, pay);
    send_frame(frame);
    run_drain(0, "t5b");
    check_payload(pay, "t5b");

    // 6a: overrun during stalled drain
    mon_clear();
    out_ready = 1'b0;
    build_good(4, frame, pay);
    send_frame(frame);
    send_byte(8'h55);
    chk_cyc = tx_cyc;
    wait_err("t6a");
    chk("t6a_code", (err_q.size() > 0) ? err_q[0] : -1, 3);
    chk("t6a_timing", err_cyc, chk_cyc + 1);
    chk("t6a_still_valid", int'(out_valid), 1);
    run_drain(0, "t6a");
    check_payload(pay, "t6a");
    $display("t6a overrun: err_code=%0d bytes=%0d", err_code, got_data.size());

    // 6b: reset mid-payload
    mon_clear();
    bl = '{8'hA5, 8'h04, 8'h01, 8'h02};
    send_frame(bl);
    chk("t6b_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #2;
    chk("t6b_busy", int'(busy), 0);
    chk("t6b_out_valid", int'(out_valid), 0);
    chk("t6b_out_data", int'(out_data), 0);
    chk("t6b_out_last", int'(out_last), 0);
    chk("t6b_err_code", int'(err_code), 0);
    chk("t6b_frame_err", int'(frame_err), 0);
    chk("t6b_frame_ok", int'(frame_ok), 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t6b_no_pulses", ok_cnt + err_q.size(), 0);
    build_good(3, frame, pay);
    send_frame(frame);
    run_drain(0, "t6b");
    check_payload(pay, "t6b");
    $display("t6b reset abort then good frame: bytes=%0d", got_data.size());

    // Randomized frames against the reference outcome
    for (int t = 0; t < 24; t++) begin
      int k;
      int nz;
      mon_clear();
      out_ready = 1'($urandom_range(0, 1));
      nz = $urandom_range(0, 2);
      for (int j = 0; j < nz; j++) begin
        logic [7:0] nb;
        nb = 8'($urandom_range(0, 255));
        if (nb == 8'hA5) nb = 8'h5A;
        send_byte(nb);
      end
      k = $urandom_range(0, 7);
      if (k == 0) begin
        frame.delete();
        frame.push_back(8'hA5);
        frame.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
        pay.delete();
      end else begin
        build_good($urandom_range(1, MAXL), frame, pay);
        if (k == 1) frame[frame.size() - 1] = 8'(frame[frame.size() - 1] + 8'($urandom_range(1, 255)));
      end
      outcome = frame_outcome(frame);
      send_frame(frame);
      if (outcome == 4) begin
        mode = $urandom_range(0, 2);
        run_drain(mode, $sformatf("r%0d", t));
        check_payload(pay, $sformatf("r%0d", t));
        chk($sformatf("r%0d_no_err", t), err_q.size(), 0);
      end else begin
        wait_err($sformatf("r%0d", t));
        chk($sformatf("r%0d_code", t), (err_q.size() > 0) ? err_q[0] : -1, outcome);
        chk($sformatf("r%0d_no_valid", t), ov_cnt, 0);
      end
      $display("rand %0d: len=%0d expected=%0d bytes=%0d errs=%0d", t, int'(frame[1]), outcome,
               got_data.size(), err_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
